// File: rtl/maze_pkg.sv
// maze_pkg -- shared types for the maze generator, item placer and renderer.
//   coord_t       : 6-bit cell coordinate
//   cell_t        : packed (x, y) cell
//   place_state_t : item placer FSM states
//   DEFAULT_SIZE_X / DEFAULT_SIZE_Y : default maze dimensions in cells
package maze_pkg;

    localparam int COORD_W        = 6;
    localparam int DEFAULT_SIZE_X = 40;
    localparam int DEFAULT_SIZE_Y = 20;
    localparam int MAX_SLOTS      = 8;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } cell_t;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        WAIT,
        CHECK,
        DONE
    } place_state_t;

endpackage

// File: rtl/item_placer_if.sv
// item_placer_if -- bundles the item placer's control, generator, wall-map
// and readback signals.
//   master : host side (drives start, random, wall data, readback index)
//   slave  : item_placer side
interface item_placer_if;
    import maze_pkg::*;

    logic       start;
    coord_t     random_x;
    coord_t     random_y;
    logic       rng_en;
    coord_t     wall_x;
    coord_t     wall_y;
    logic       wall_bit;
    logic [2:0] rd_idx;
    coord_t     rd_x;
    coord_t     rd_y;
    logic       rd_valid;
    logic [3:0] placed_count;
    logic       busy;
    logic       done;
    logic       fail;

    modport master (
        output start, random_x, random_y, wall_bit, rd_idx,
        input  rng_en, wall_x, wall_y, rd_x, rd_y, rd_valid,
               placed_count, busy, done, fail
    );

    modport slave (
        input  start, random_x, random_y, wall_bit, rd_idx,
        output rng_en, wall_x, wall_y, rd_x, rd_y, rd_valid,
               placed_count, busy, done, fail
    );

endinterface

// File: rtl/item_slots.sv
// item_slots -- storage for up to MAX_SLOTS placed items plus a parallel
// duplicate comparator.
//   clk, reset     : clock, synchronous active-high reset
//   clear          : zero every slot (start of a new run)
//   wr_en/wr_idx/wr_cell : write one slot
//   count          : number of valid slots; masks the duplicate compare
//   lookup -> hit  : 1 when lookup matches any valid slot
//   rd_idx -> rd_cell : combinational readback
module item_slots
    import maze_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  cell_t      wr_cell,
    input  logic [3:0] count,
    input  cell_t      lookup,
    output logic       hit,
    input  logic [2:0] rd_idx,
    output cell_t      rd_cell
);

    cell_t                slot_q [MAX_SLOTS];
    logic [MAX_SLOTS-1:0] match;

    // NOTE: this storage is reset explicitly because readback of a freshly
    // reset block must return zero coordinates, not X.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < MAX_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else if (wr_en) begin
            slot_q[wr_idx] <= wr_cell;
        end
    end

    // All slots compared at once; slots at or above count hold stale data.
    always_comb begin
        match = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            match[i] = (4'(i) < count) && (slot_q[i] == lookup);
        end
    end

    assign hit     = |match;
    assign rd_cell = slot_q[rd_idx];

endmodule

// File: rtl/item_placer.sv
// item_placer -- places NUM_ITEMS items on free, distinct maze cells using
// candidates from an upstream generator, checking each against the wall map.
//   clk, reset : clock, synchronous active-high reset
//   bus        : item_placer_if.slave (start, random_x/y, rng_en, wall_x/y,
//                wall_bit, rd_idx, rd_x/y, rd_valid, placed_count,
//                busy, done, fail)
module item_placer
    import maze_pkg::*;
#(
    parameter int SIZE_X    = DEFAULT_SIZE_X,
    parameter int SIZE_Y    = DEFAULT_SIZE_Y,
    parameter int NUM_ITEMS = 8,
    parameter int MAX_TRIES = 255,
    parameter int START_X   = 0,
    parameter int START_Y   = 0
) (
    input  logic         clk,
    input  logic         reset,
    item_placer_if.slave bus
);

    localparam cell_t START_CELL = '{x: coord_t'(START_X), y: coord_t'(START_Y)};

    place_state_t state_q, state_d;
    cell_t        cand_q, cand_d;
    logic [3:0]   count_q, count_d;
    logic [7:0]   try_q, try_d, try_inc;
    logic         done_q, done_d;
    logic         fail_q, fail_d;
    logic         slot_wr, slot_clear, dup_hit, reject;
    cell_t        rd_cell;

    item_slots u_slots (
        .clk     (clk),
        .reset   (reset),
        .clear   (slot_clear),
        .wr_en   (slot_wr),
        .wr_idx  (count_q[2:0]),
        .wr_cell (cand_q),
        .count   (count_q),
        .lookup  (cand_q),
        .hit     (dup_hit),
        .rd_idx  (bus.rd_idx),
        .rd_cell (rd_cell)
    );

    // wall_bit belongs to the address presented during WAIT, so it is
    // only meaningful while in CHECK.
    assign reject = (int'(cand_q.x) >= SIZE_X) || (int'(cand_q.y) >= SIZE_Y) ||
                    bus.wall_bit || (cand_q == START_CELL) || dup_hit;

    assign try_inc = (try_q == 8'hFF) ? try_q : try_q + 8'd1;

    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        count_d    = count_q;
        try_d      = try_q;
        done_d     = done_q;
        fail_d     = fail_q;
        slot_wr    = 1'b0;
        slot_clear = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    count_d    = '0;
                    try_d      = '0;
                    done_d     = 1'b0;
                    fail_d     = 1'b0;
                    slot_clear = 1'b1;
                    state_d    = SAMPLE;
                end
            end
            SAMPLE: begin
                cand_d  = '{x: bus.random_x, y: bus.random_y};
                state_d = WAIT;
            end
            WAIT: state_d = CHECK;
            CHECK: begin
                if (!reject) begin
                    slot_wr = 1'b1;
                    count_d = count_q + 4'd1;
                    if (int'(count_q) + 1 >= NUM_ITEMS) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = SAMPLE;
                    end
                end else begin
                    try_d = try_inc;
                    if (int'(try_inc) >= MAX_TRIES) begin
                        done_d  = 1'b1;
                        fail_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = SAMPLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= '0;
            count_q <= '0;
            try_q   <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            count_q <= count_d;
            try_q   <= try_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.busy         = (state_q == SAMPLE) || (state_q == WAIT) || (state_q == CHECK);
    assign bus.rng_en       = bus.busy;
    assign bus.wall_x       = cand_q.x;
    assign bus.wall_y       = cand_q.y;
    assign bus.placed_count = count_q;
    assign bus.done         = done_q;
    assign bus.fail         = fail_q;
    assign bus.rd_x         = rd_cell.x;
    assign bus.rd_y         = rd_cell.y;
    assign bus.rd_valid     = ({1'b0, bus.rd_idx} < count_q);

endmodule

// File: tb/tb_item_placer.sv
// tb_item_placer -- directed self-checking bench for item_placer.
// dut  : NUM_ITEMS=2, MAX_TRIES=4, registered wall map with a wall at (7,7)
// dut3 : NUM_ITEMS=3, used for the mid-run reset and start-while-busy cases
module tb_item_placer;
    import maze_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic wall_on;
    int   total = 0;
    int   bad   = 0;

    item_placer_if bus ();
    item_placer_if bus3 ();

    item_placer #(.NUM_ITEMS(2), .MAX_TRIES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    item_placer #(.NUM_ITEMS(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    // Wall map with one cycle read latency; the only wall is (7,7).
    always @(posedge clk)
        bus.wall_bit <= wall_on && (bus.wall_x == 6'd7) && (bus.wall_y == 6'd7);

    assign bus3.wall_bit = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns #1 after the accepting edge.
    task automatic start_run();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Present one candidate and let it run through SAMPLE, WAIT, CHECK.
    task automatic feed(input int x, input int y);
        bus.random_x = coord_t'(x);
        bus.random_y = coord_t'(y);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        wall_on       = 1'b0;
        bus.start     = 1'b0;
        bus.random_x  = '0;
        bus.random_y  = '0;
        bus.rd_idx    = '0;
        bus3.start    = 1'b0;
        bus3.random_x = '0;
        bus3.random_y = '0;
        bus3.rd_idx   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(bus.busy), 0);
        check("rst rng_en", 32'(bus.rng_en), 0);
        check("rst done", 32'(bus.done), 0);
        check("rst fail", 32'(bus.fail), 0);
        check("rst count", 32'(bus.placed_count), 0);
        check("rst wall_x", 32'(bus.wall_x), 0);
        check("rst wall_y", 32'(bus.wall_y), 0);
        check("rst rd_valid", 32'(bus.rd_valid), 0);
        reset = 1'b0;

        // Two clean placements: done exactly 6 cycles after start.
        start_run();
        check("s037 busy", 32'(bus.busy), 1);
        check("s037 rng_en", 32'(bus.rng_en), 1);
        feed(3, 4);
        check("s037 count1", 32'(bus.placed_count), 1);
        check("s037 not done", 32'(bus.done), 0);
        feed(5, 6);
        check("s037 done", 32'(bus.done), 1);
        check("s037 fail", 32'(bus.fail), 0);
        check("s037 idle", 32'(bus.busy), 0);
        check("s037 count2", 32'(bus.placed_count), 2);
        bus.rd_idx = 3'd0;
        #1;
        check("s037 rd0 x", 32'(bus.rd_x), 3);
        check("s037 rd0 y", 32'(bus.rd_y), 4);
        check("s037 rd0 valid", 32'(bus.rd_valid), 1);
        bus.rd_idx = 3'd1;
        #1;
        check("s037 rd1 x", 32'(bus.rd_x), 5);
        check("s037 rd1 y", 32'(bus.rd_y), 6);
        bus.rd_idx = 3'd2;
        #1;
        check("s037 rd2 valid", 32'(bus.rd_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        check("s037 done held", 32'(bus.done), 1);

        // Out-of-range rejects; a start from DONE clears status.
        start_run();
        check("s038 done clr", 32'(bus.done), 0);
        check("s038 count clr", 32'(bus.placed_count), 0);
        feed(45, 4);
        feed(3, 25);
        check("s038 count0", 32'(bus.placed_count), 0);
        feed(3, 4);
        check("s038 count1", 32'(bus.placed_count), 1);
        check("s038 tries", 32'(dut.try_q), 2);
        feed(10, 10);
        check("s038 done", 32'(bus.done), 1);

        // Wall rejection.
        wall_on = 1'b1;
        start_run();
        feed(7, 7);
        check("s039 wall rej", 32'(bus.placed_count), 0);
        feed(8, 8);
        check("s039 count1", 32'(bus.placed_count), 1);
        bus.rd_idx = 3'd0;
        #1;
        check("s039 rd0 x", 32'(bus.rd_x), 8);
        check("s039 rd0 y", 32'(bus.rd_y), 8);
        feed(9, 9);
        check("s039 done", 32'(bus.done), 1);
        wall_on = 1'b0;

        // Duplicate and start-cell rejection.
        start_run();
        feed(3, 4);
        check("s040 count1", 32'(bus.placed_count), 1);
        feed(3, 4);
        check("s040 dup rej", 32'(bus.placed_count), 1);
        feed(0, 0);
        check("s040 start rej", 32'(bus.placed_count), 1);
        feed(5, 6);
        check("s040 done", 32'(bus.done), 1);
        check("s040 fail", 32'(bus.fail), 0);
        check("s040 count2", 32'(bus.placed_count), 2);
        bus.rd_idx = 3'd1;
        #1;
        check("s040 rd1 x", 32'(bus.rd_x), 5);

        // Try budget exhausted: fail and done after 12 cycles.
        start_run();
        feed(0, 0);
        feed(0, 0);
        feed(0, 0);
        check("s041 not done", 32'(bus.done), 0);
        feed(0, 0);
        check("s041 fail", 32'(bus.fail), 1);
        check("s041 done", 32'(bus.done), 1);
        check("s041 count", 32'(bus.placed_count), 0);
        check("s041 idle", 32'(bus.busy), 0);

        // Start ignored while busy, then reset in WAIT of item 3.
        @(negedge clk);
        bus3.start    = 1'b1;
        bus3.random_x = 6'd3;
        bus3.random_y = 6'd4;
        @(posedge clk);
        #1 bus3.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("s042 count1", 32'(bus3.placed_count), 1);
        bus3.random_x = 6'd5;
        bus3.random_y = 6'd6;
        @(posedge clk);
        #1 bus3.start = 1'b1;
        @(posedge clk);
        #1 bus3.start = 1'b0;
        @(posedge clk);
        #1;
        check("s042 busy start ignored", 32'(bus3.placed_count), 2);
        check("s042 still busy", 32'(bus3.busy), 1);
        bus3.random_x = 6'd9;
        bus3.random_y = 6'd9;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("s042 state", 32'(dut3.state_q), 32'(IDLE));
        check("s042 count", 32'(bus3.placed_count), 0);
        check("s042 busy", 32'(bus3.busy), 0);
        check("s042 done", 32'(bus3.done), 0);
        check("s042 wall_x", 32'(bus3.wall_x), 0);
        bus3.rd_idx = 3'd1;
        #1;
        check("s042 rd1 x", 32'(bus3.rd_x), 0);
        check("s042 rd1 valid", 32'(bus3.rd_valid), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("s042 stays idle", 32'(bus3.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
